// File: rtl/ni_arb_pkg.sv
`default_nettype none
// ============================================================================
// ni_arb_pkg : shared types and helpers for the NI request arbiter
// Rev 1.0
// ============================================================================
package ni_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int DEST_W = 8;
    localparam int MSGT_W = 3;

    // Cyclic successor of idx in the range 0..n-1.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_select.sv
`default_nettype none
// ============================================================================
// rr_grant_select : first requester at or after ptr, searching cyclically
// Rev 1.0
// ============================================================================
module rr_grant_select #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     grant_idx,
    output logic               found
);

    localparam int CW = IDW + 1;

    logic [CW-1:0] w_cand;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One spare bit holds ptr+k before folding back into range.
            w_cand = {1'b0, ptr} + CW'(k);
            if (w_cand >= CW'(NUM_REQ)) begin
                w_cand = w_cand - CW'(NUM_REQ);
            end
            if (!found && req[w_cand[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = w_cand[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ni_request_arbiter.sv
`default_nettype none
// ============================================================================
// ni_request_arbiter : round-robin sharing of one NI memory-side port among
// NUM_REQ masters. Define ARB_TIMEOUT_EN to enable the ISSUE watchdog.
// Rev 1.0
// ============================================================================
module ni_request_arbiter
    import ni_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH     = 32,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*DEST_W-1:0]     req_dest_id,
    input  logic [NUM_REQ*MSGT_W-1:0]     req_msg_type,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_err,
    output logic                          ni_mem_write,
    output logic                          ni_mem_read,
    output logic [ADDR_WIDTH-1:0]         ni_mem_addr,
    output logic [DATA_WIDTH-1:0]         ni_mem_wdata,
    output logic [DEST_W-1:0]             ni_dest_id,
    output logic [MSGT_W-1:0]             ni_msg_type,
    input  logic [DATA_WIDTH-1:0]         ni_mem_rdata,
    input  logic                          ni_mem_ready,
    output logic                          busy,
    output logic [IDW-1:0]                grant_id
);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     w_gidx;
    logic               w_found;
    logic               w_timeout;
    logic               w_complete;
    logic [NUM_REQ-1:0] w_req;

    assign w_req      = req_write | req_read;
    assign w_complete = (r_state == ISSUE) && (ni_mem_ready || w_timeout);
    assign busy       = (r_state != IDLE);

    rr_grant_select #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_sel (
        .req       (w_req),
        .ptr       (r_ptr),
        .grant_idx (w_gidx),
        .found     (w_found)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] r_cnt;

    // Counter is parked at zero in IDLE, so every ISSUE entry starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= r_cnt + TCW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == ISSUE) && !ni_mem_ready
                       && (r_cnt == TCW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_next = ISSUE;
            ISSUE:   if (w_complete) w_state_next = GAP;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ni_mem_write <= 1'b0;
            ni_mem_read  <= 1'b0;
            ni_mem_addr  <= '0;
            ni_mem_wdata <= '0;
            ni_dest_id   <= '0;
            ni_msg_type  <= '0;
            req_done     <= '0;
            req_rdata    <= '0;
            req_err      <= 1'b0;
            grant_id     <= '0;
            r_ptr        <= '0;
        end else begin
            req_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        grant_id     <= w_gidx;
                        // A simultaneous read+write issues the write only.
                        ni_mem_write <= req_write[w_gidx];
                        ni_mem_read  <= req_read[w_gidx] & ~req_write[w_gidx];
                        ni_mem_addr  <= req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
                        ni_mem_wdata <= req_wdata[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
                        ni_dest_id   <= req_dest_id[int'(w_gidx)*DEST_W +: DEST_W];
                        ni_msg_type  <= req_msg_type[int'(w_gidx)*MSGT_W +: MSGT_W];
                    end
                end
                ISSUE: begin
                    if (w_complete) begin
                        ni_mem_write       <= 1'b0;
                        ni_mem_read        <= 1'b0;
                        req_rdata          <= w_timeout ? '0 : ni_mem_rdata;
                        req_err            <= w_timeout;
                        req_done[grant_id] <= 1'b1;
                        r_ptr              <= IDW'(rr_next(32'(grant_id), NUM_REQ));
                    end
                end
                GAP: begin
                    req_err <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ni_request_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ni_request_arbiter : directed self-checking bench for ni_request_arbiter
// Rev 1.0
// ============================================================================
module tb_ni_request_arbiter;

    localparam int NUM_REQ = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_write, req_read, req_done;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  req_dest_id;
    logic [11:0]  req_msg_type;
    logic [31:0]  req_rdata;
    logic         req_err;
    logic         ni_mem_write, ni_mem_read;
    logic [31:0]  ni_mem_addr, ni_mem_wdata;
    logic [7:0]   ni_dest_id;
    logic [2:0]   ni_msg_type;
    logic [31:0]  ni_mem_rdata;
    logic         ni_mem_ready;
    logic         busy;
    logic [1:0]   grant_id;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          hi;
    int          idx;
    int          ni_lat = 3;        // number of cycles the command is held before completion
    bit          ni_respond = 1'b1;
    logic [31:0] ni_rdata_val = '0;
    int          ni_cnt;

    always #5 clk = ~clk;

    ni_request_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_write    (req_write),
        .req_read     (req_read),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_dest_id  (req_dest_id),
        .req_msg_type (req_msg_type),
        .req_done     (req_done),
        .req_rdata    (req_rdata),
        .req_err      (req_err),
        .ni_mem_write (ni_mem_write),
        .ni_mem_read  (ni_mem_read),
        .ni_mem_addr  (ni_mem_addr),
        .ni_mem_wdata (ni_mem_wdata),
        .ni_dest_id   (ni_dest_id),
        .ni_msg_type  (ni_msg_type),
        .ni_mem_rdata (ni_mem_rdata),
        .ni_mem_ready (ni_mem_ready),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    // NI model: registered ready pulse so the command is visible for ni_lat cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ni_cnt       <= 0;
            ni_mem_ready <= 1'b0;
            ni_mem_rdata <= '0;
        end else begin
            ni_mem_ready <= 1'b0;
            if ((ni_mem_write || ni_mem_read) && !ni_mem_ready) begin
                ni_cnt <= ni_cnt + 1;
                if (ni_respond && ni_cnt == ni_lat - 2) begin
                    ni_mem_ready <= 1'b1;
                    ni_mem_rdata <= ni_rdata_val;
                end
            end else begin
                ni_cnt <= 0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_cmd(input int m, input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d, input logic [7:0] dst, input logic [2:0] mt);
        req_write[m]            = w;
        req_read[m]             = r;
        req_addr[m*32 +: 32]    = a;
        req_wdata[m*32 +: 32]   = d;
        req_dest_id[m*8 +: 8]   = dst;
        req_msg_type[m*3 +: 3]  = mt;
    endtask

    // Returns on the negedge where req_done[m] is seen; n_hi counts command-high negedges.
    task automatic wait_done(input int m, input string tag, output int n_hi);
        int cyc = 0;
        n_hi = 0;
        while (req_done[m] !== 1'b1 && cyc < 100) begin
            n_hi += int'(ni_mem_write | ni_mem_read);
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_done"}, 64'(req_done[m]), 64'd1);
    endtask

    task automatic wait_any(output int who);
        int cyc = 0;
        who = -1;
        while (req_done == 4'd0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < NUM_REQ; i++) if (req_done[i]) who = i;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_write = '0; req_read = '0; req_addr = '0; req_wdata = '0;
        req_dest_id = '0; req_msg_type = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant_id, 0);
        check_val("rst_done", req_done, 0);
        check_val("rst_cmd", {ni_mem_write, ni_mem_read}, 0);
        check_val("rst_addr", ni_mem_addr, 0);
        check_val("rst_rdata", req_rdata, 0);
        check_val("rst_err", req_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_busy", busy, 0);
        check_val("idle_cmd", {ni_mem_write, ni_mem_read}, 0);

        // Single write from master 2
        ni_rdata_val = 32'hFFFF0000;
        set_cmd(2, 1, 0, 32'h40, 32'hDEADBEEF, 8'd5, 3'd1);
        @(negedge clk);
        check_val("wr_grant", grant_id, 2);
        check_val("wr_cmd", {ni_mem_write, ni_mem_read}, 2'b10);
        check_val("wr_addr", ni_mem_addr, 32'h40);
        check_val("wr_wdata", ni_mem_wdata, 32'hDEADBEEF);
        check_val("wr_dest", ni_dest_id, 5);
        check_val("wr_msgt", ni_msg_type, 1);
        check_val("wr_busy", busy, 1);
        wait_done(2, "wr", hi);
        check_val("wr_hi_cycles", hi, 3);
        check_val("wr_done_vec", req_done, 4'b0100);
        check_val("wr_gap_cmd", ni_mem_write, 0);
        check_val("wr_gap_busy", busy, 1);
        check_val("wr_err", req_err, 0);
        req_write[2] = 1'b0;
        @(negedge clk);
        check_val("wr_done_pulse", req_done, 0);
        check_val("wr_idle_busy", busy, 0);

        // Pointer is now 3: masters 0 and 3 read together, 3 wins, then wrap to 0
        ni_rdata_val = 32'hA5A50003;
        set_cmd(3, 0, 1, 32'h300, 32'h0, 8'd7, 3'd2);
        set_cmd(0, 0, 1, 32'h100, 32'h0, 8'd1, 3'd2);
        @(negedge clk);
        check_val("ptr_grant3", grant_id, 3);
        check_val("rd3_cmd", {ni_mem_write, ni_mem_read}, 2'b01);
        check_val("rd3_addr", ni_mem_addr, 32'h300);
        req_addr[3*32 +: 32] = 32'h3FC;
        @(negedge clk);
        check_val("stable_addr", ni_mem_addr, 32'h300);
        wait_done(3, "rd3", hi);
        check_val("rd3_rdata", req_rdata, 32'hA5A50003);
        check_val("rd3_gap_read", ni_mem_read, 0);
        req_read[3] = 1'b0;
        ni_rdata_val = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        check_val("wrap_grant0", grant_id, 0);
        check_val("rd0_cmd", {ni_mem_write, ni_mem_read}, 2'b01);
        check_val("rd0_addr", ni_mem_addr, 32'h100);
        wait_done(0, "rd0", hi);
        check_val("rd0_rdata", req_rdata, 32'h12345678);
        check_val("rd0_done_vec", req_done, 4'b0001);
        check_val("rd0_gap_read", ni_mem_read, 0);
        req_read[0] = 1'b0;
        @(negedge clk);

        // Read+write collision on master 1
        set_cmd(1, 1, 1, 32'h200, 32'hCAFE0001, 8'd2, 3'd0);
        @(negedge clk);
        check_val("col_grant", grant_id, 1);
        check_val("col_cmd", {ni_mem_write, ni_mem_read}, 2'b10);
        wait_done(1, "col_wr", hi);
        req_write[1] = 1'b0;
        req_read[1]  = 1'b0;
        @(negedge clk);
        check_val("col_read_dropped", {busy, ni_mem_read}, 0);
        req_read[1] = 1'b1;
        @(negedge clk);
        check_val("col_reread_cmd", {ni_mem_write, ni_mem_read}, 2'b01);
        check_val("col_reread_grant", grant_id, 1);
        wait_done(1, "col_rd", hi);
        req_read[1] = 1'b0;
        @(negedge clk);

        // Reset in the middle of ISSUE
        ni_respond = 1'b0;
        set_cmd(2, 1, 0, 32'h44, 32'h1, 8'd3, 3'd0);
        @(negedge clk);
        check_val("mid_busy", busy, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_cmd", {ni_mem_write, ni_mem_read}, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_grant", grant_id, 0);
        check_val("mid_rst_addr", ni_mem_addr, 0);
        check_val("mid_rst_done", req_done, 0);
        req_write = '0;
        ni_respond = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("mid_rst_nodone", req_done, 0);
        end

        // Fairness: all four masters request continuously, pointer back at 0
        for (int m = 0; m < NUM_REQ; m++) set_cmd(m, 1, 0, 32'h1000 + 32'(m), 32'(m), 8'(m), 3'd0);
        for (int n = 0; n < 6; n++) begin
            wait_any(idx);
            check_val("fair_order", idx, n % 4);
            check_val("fair_onehot", $countones(req_done), 1);
            if (n == 5) req_write = '0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_val("fair_end_busy", busy, 0);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: NI never answers
        ni_respond = 1'b0;
        set_cmd(1, 0, 1, 32'h500, 32'h0, 8'd9, 3'd0);
        @(negedge clk);
        check_val("tmo_cmd", ni_mem_read, 1);
        wait_done(1, "tmo", hi);
        check_val("tmo_cycles", hi, 8);
        check_val("tmo_err", req_err, 1);
        check_val("tmo_rdata", req_rdata, 0);
        req_read[1] = 1'b0;
        @(negedge clk);
        check_val("tmo_err_clear", req_err, 0);
        ni_respond = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ni_request_arbiter.md
Name: ni_request_arbiter

Overview:
- Shares one network interface's local memory-side port among NUM_REQ local masters (cores, DMA, debug).
- Round-robin arbitration between masters; a grant is held for one whole NI transaction.
- The granted command is registered and held stable until the NI returns mem_ready.
- Completion data and a done pulse are routed back to the owning master; one idle gap cycle is inserted between transactions so the NI is back in IDLE before the next command.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, data width; matches the NI
- ADDR_WIDTH, 32, address width; matches the NI
- TIMEOUT_CYCLES, 1024, watchdog limit in ISSUE (used only with ARB_TIMEOUT_EN)
- IDW, $clog2(NUM_REQ), width of the grant index (localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_write  in  NUM_REQ  per-master write request; held until that master's req_done
- req_read  in  NUM_REQ  per-master read request; held until that master's req_done
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i belongs to master i
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_dest_id  in  NUM_REQ*8  flattened destination node IDs
- req_msg_type  in  NUM_REQ*3  flattened message types
- req_done  out  NUM_REQ  one-cycle completion pulse per master
- req_rdata  out  DATA_WIDTH  read data; valid while any req_done bit is high
- req_err  out  1  completion was a timeout abort; 0 when ARB_TIMEOUT_EN is undefined
- ni_mem_write  out  1  to NI mem_write
- ni_mem_read  out  1  to NI mem_read
- ni_mem_addr  out  ADDR_WIDTH  to NI mem_addr
- ni_mem_wdata  out  DATA_WIDTH  to NI mem_wdata
- ni_dest_id  out  8  to NI dest_id
- ni_msg_type  out  3  to NI msg_type
- ni_mem_rdata  in  DATA_WIDTH  from NI mem_rdata
- ni_mem_ready  in  1  from NI mem_ready (registered pulse)
- busy  out  1  high in ISSUE and GAP
- grant_id  out  IDW  index of the current or most recent grant

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - all outputs 0; state IDLE
  - round-robin pointer = 0 (master 0 has highest priority first)
- Request: master i requests when req_write[i] | req_read[i].
- IDLE:
  - If any request is pending, pick the first requesting index at or after the pointer (cyclic).
  - Register that master's command into the ni_* outputs, set grant_id, go to ISSUE.
  - Latency: request visible at cycle t -> ni_mem_* driven at t+1.
- Read/write collision: if a master raises read and write together, the write is issued and the read flag is dropped. The master must re-request the read after its done.
- ISSUE:
  - ni_* outputs are held constant; changes on req_* inputs are ignored.
  - On ni_mem_ready=1: latch ni_mem_rdata into req_rdata (writes latch it too; the value is don't-care).
  - In the same cycle: clear ni_mem_write/ni_mem_read, pulse req_done[grant_id] next cycle, pointer <= grant_id+1 mod NUM_REQ, go to GAP.
- GAP:
  - Lasts exactly one cycle with ni_mem_write = ni_mem_read = 0. This guarantees the NI has left its RECV state.
  - req_done[grant_id] is high during GAP, then IDLE.
  - A registered master drops its request on the edge that ends GAP, so it is not re-granted.
- No request pending in IDLE: the arbiter stays in IDLE and the ni_* command bits stay 0.
- Pointer wrap: after a grant to NUM_REQ-1 the pointer becomes 0.
- A request that drops while not granted is lost silently; no error is raised.
- Back-to-back throughput: one transaction per (NI latency + 2) cycles. Each of N continuously requesting masters is served once every N transactions.
- Reset mid-transaction:
  - Everything returns to reset values immediately.
  - No req_done is issued for the aborted transaction.
  - The NI shares rst_n and is reset together with the arbiter.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A cycle counter runs in ISSUE and is cleared on entry to ISSUE.
  - When the counter reaches TIMEOUT_CYCLES-1 without ni_mem_ready: drop the command, set req_rdata=0 and req_err=1 together with req_done[grant_id], advance the pointer, go to GAP.
  - req_err is cleared in the cycle after GAP.
- ARB_TIMEOUT_EN undefined:
  - No counter; ISSUE waits indefinitely.
  - The req_err port exists but is tied to 0.

Decomposition:
- Package ni_arb_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, GAP=2'd2
  - field widths DEST_W=8, MSGT_W=3
  - function for cyclic next-index
- Sub-module rr_grant_select (combinational):
  - inputs: request vector, pointer
  - outputs: grant index and a found flag
  - used once, in IDLE.

Test Plan:
- Single write: master 2 writes addr 0x40, wdata 0xDEADBEEF, dest 5; NI model returns ready after 3 cycles -> ni_mem_write high for exactly those cycles, req_done[2] a single pulse, grant_id=2, pointer=3.
- Single read: master 0 reads; NI returns rdata 0x12345678 -> req_rdata=0x12345678 while req_done[0]=1; ni_mem_read low during GAP.
- Fairness: all 4 masters hold continuous requests -> grant order 0,1,2,3,0,1; no master is granted twice in a row while others wait.
- Collision: master 1 asserts read and write together -> write issued; the read is served only after the master re-requests it.
- Stability: master 3 changes req_addr during ISSUE -> ni_mem_addr unchanged until GAP.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): NI never returns ready -> req_done and req_err pulse together 8 cycles after ISSUE entry, req_rdata=0. A separate run asserts rst_n low mid-ISSUE -> all outputs 0 at once, no done pulse.
